// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the multi-cycle MIPS control path.
//   state_e    : control FSM state encoding (also exported on state_dbg)
//   OP_* / FUNCT_* : instruction field constants used by the decoder
//   pc_src_e   : PC source select encoding driven on pc_src
package mips_cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FUNCT_JR = 6'h08;

    // ALU opcode used for load/store effective-address computation.
    localparam logic [5:0] ALU_OP_ADDR = 6'h09;

    typedef enum logic [1:0] {
        PC_SRC_SEQ    = 2'd0,
        PC_SRC_BRANCH = 2'd1,
        PC_SRC_RS     = 2'd2
    } pc_src_e;

endpackage

// File: rtl/mips_cpu_control_fsm_if.sv
// Memory handshake between the control FSM and the memory port.
//   mem_read, mem_write : access strobes (never both high)
//   addr_sel            : 0 = PC address (fetch), 1 = ALU address (data)
//   waitrequest         : memory stall, hold the current access while high
interface mips_cpu_mem_if;

    logic mem_read;
    logic mem_write;
    logic addr_sel;
    logic waitrequest;

    modport master (
        output mem_read,
        output mem_write,
        output addr_sel,
        input  waitrequest
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  addr_sel,
        output waitrequest
    );

endinterface

// File: rtl/mips_cpu_control_fsm_decode.sv
// Combinational opcode classification for the control FSM.
//   opcode, funct : instruction fields from the IR
//   is_*          : one-hot-or-zero instruction class flags
module mips_cpu_decode
    import mips_cpu_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       is_rtype_alu,
    output logic       is_itype_alu,
    output logic       is_branch,
    output logic       is_jr,
    output logic       is_load,
    output logic       is_store
);

    always_comb begin
        is_rtype_alu = (opcode == OP_RTYPE) && (funct != FUNCT_JR);
        is_jr        = (opcode == OP_RTYPE) && (funct == FUNCT_JR);
        is_itype_alu = (opcode >= OP_ADDIU) && (opcode <= OP_LUI);
        is_branch    = (opcode == OP_BEQ) || (opcode == OP_BNE);
        is_load      = (opcode == OP_LW);
        is_store     = (opcode == OP_SW);
    end

endmodule

// File: rtl/mips_cpu_control_fsm.sv
// Multi-cycle MIPS control FSM: IDLE -> FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   opcode, funct       : IR fields (IR is stable outside FETCH)
//   sig_branch          : ALU branch-taken flag, valid in EXEC
//   jump_target_zero    : jr target is 0, which halts the CPU
//   mem                 : memory handshake (read/write/addr_sel/waitrequest)
//   active ... pc_src   : datapath strobes and selects
//   alu_control/opcode  : ALU function codes, driven only in EXEC
//   state_dbg           : current state encoding
module mips_cpu_control_fsm
    import mips_cpu_pkg::*;
#(
    parameter int unsigned FETCH_WAIT_MAX = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic                 sig_branch,
    input  logic                 jump_target_zero,
    mips_cpu_mem_if.master       mem,
    output logic                 active,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic [1:0]           pc_src,
    output logic [5:0]           alu_control,
    output logic [5:0]           alu_opcode,
    output logic [2:0]           state_dbg
);

    state_e state, state_next;

    logic is_rtype_alu, is_itype_alu, is_branch, is_jr, is_load, is_store;

    mips_cpu_decode u_decode (
        .opcode       (opcode),
        .funct        (funct),
        .is_rtype_alu (is_rtype_alu),
        .is_itype_alu (is_itype_alu),
        .is_branch    (is_branch),
        .is_jr        (is_jr),
        .is_load      (is_load),
        .is_store     (is_store)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        active        = 1'b0;
        mem.mem_read  = 1'b0;
        mem.mem_write = 1'b0;
        mem.addr_sel  = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        pc_src        = PC_SRC_SEQ;
        alu_control   = '0;
        alu_opcode    = '0;

        unique case (state)
            ST_IDLE: begin
                state_next = ST_FETCH;
            end

            ST_FETCH: begin
                active       = 1'b1;
                mem.mem_read = 1'b1;
                // IR load and PC+4 update happen only on the cycle the read completes.
                if (!mem.waitrequest) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = ST_DECODE;
                end
            end

            ST_DECODE: begin
                active     = 1'b1;
                state_next = ST_EXEC;
            end

            ST_EXEC: begin
                active      = 1'b1;
                alu_control = funct;
                alu_opcode  = (is_load || is_store) ? ALU_OP_ADDR : opcode;
                if (is_rtype_alu || is_itype_alu) begin
                    state_next = ST_WB;
                end else if (is_branch) begin
                    pc_write   = sig_branch;
                    pc_src     = PC_SRC_BRANCH;
                    state_next = ST_FETCH;
                end else if (is_jr) begin
                    pc_write   = 1'b1;
                    pc_src     = PC_SRC_RS;
                    state_next = jump_target_zero ? ST_HALT : ST_FETCH;
                end else if (is_load || is_store) begin
                    state_next = ST_MEM;
                end else begin
                    state_next = ST_FETCH;
                end
            end

            ST_MEM: begin
                active        = 1'b1;
                mem.addr_sel  = 1'b1;
                mem.mem_read  = is_load;
                mem.mem_write = is_store;
                if (!mem.waitrequest) begin
                    state_next = is_load ? ST_WB : ST_FETCH;
                end
            end

            ST_WB: begin
                active     = 1'b1;
                reg_write  = 1'b1;
                reg_dst    = is_rtype_alu;
                mem_to_reg = is_load;
                state_next = ST_FETCH;
            end

            ST_HALT: begin
                state_next = ST_HALT;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign state_dbg = state;

    // Debug-only watchdog on consecutive fetch stall cycles; absent when the bound is 0.
    generate
        if (FETCH_WAIT_MAX > 0) begin : g_fetch_watchdog
            int unsigned stall_cnt;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    stall_cnt <= '0;
                end else if (state == ST_FETCH && mem.waitrequest) begin
                    stall_cnt <= stall_cnt + 1;
                end else begin
                    stall_cnt <= '0;
                end
            end

            always_ff @(posedge clk) begin
                if (!reset) begin
                    assert (stall_cnt <= FETCH_WAIT_MAX);
                end
            end
        end
    endgenerate

endmodule

// File: doc/mips_cpu_control_fsm.md
MIPS_CPU_CONTROL_FSM -- requirements
Module: mips_cpu_control_fsm

Interface
REQ-001 SHALL have parameter: FETCH_WAIT_MAX, 0, debug bound on waitrequest stall cycles (0 = unbounded).
REQ-002 SHALL have port: clk  in  1  single system clock, rising-edge active.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: opcode  in  6  instruction bits [31:26], from the IR.
REQ-005 SHALL have port: funct  in  6  instruction bits [5:0], from the IR.
REQ-006 SHALL have port: sig_branch  in  1  ALU branch-taken flag, valid in EXEC.
REQ-007 SHALL have port: jump_target_zero  in  1  jr target register equals 0.
REQ-008 SHALL have port: waitrequest  in  1  memory stall.
REQ-009 SHALL have ports: active, mem_read, mem_write, ir_write, pc_write, reg_write, reg_dst, mem_to_reg, addr_sel  out  1 each  CPU/datapath strobes and selects.
REQ-010 SHALL have port: pc_src  out  2  PC source: 0 = PC+4, 1 = branch target, 2 = rs.
REQ-011 SHALL have port: alu_control  out  6  ALU function code.
REQ-012 SHALL have port: alu_opcode  out  6  ALU opcode.
REQ-013 SHALL have port: state_dbg  out  3  current state encoding.

Function
REQ-014 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT; one transition per clk edge at most.
REQ-015 IDLE SHALL drive all outputs 0 and go to FETCH on the first edge after reset is low.
REQ-016 FETCH SHALL assert mem_read with addr_sel=0; it SHALL hold while waitrequest=1. On the first cycle with waitrequest=0 it SHALL pulse ir_write and pc_write (pc_src=0) for exactly one cycle, then go to DECODE.
REQ-017 DECODE SHALL be one cycle with no strobes, then go to EXEC.
REQ-018 EXEC SHALL drive alu_control=funct and alu_opcode=opcode, except lw (0x23) and sw (0x2b), which SHALL drive alu_opcode=0x09 (address add).
REQ-019 EXEC, R-type ALU/shift (opcode 0, funct not 0x08) or I-type ALU (0x09, 0x0A, 0x0B, 0x0C, 0x0D, 0x0E, 0x0F): go to WB.
REQ-020 EXEC, beq/bne (0x04/0x05): pc_write=sig_branch with pc_src=1, then go to FETCH.
REQ-021 EXEC, jr (opcode 0, funct 0x08): pc_write=1 with pc_src=2; go to HALT if jump_target_zero=1, else to FETCH.
REQ-022 EXEC, lw/sw: go to MEM. Any other opcode: treat as NOP and go to FETCH.
REQ-023 MEM lw: assert mem_read with addr_sel=1, hold while waitrequest=1, then go to WB.
REQ-024 MEM sw: assert mem_write with addr_sel=1, hold while waitrequest=1, then go to FETCH.
REQ-025 WB SHALL pulse reg_write for one cycle, with reg_dst=1 for R-type and mem_to_reg=1 for lw, then go to FETCH.
REQ-026 HALT SHALL drive active=0 and all strobes 0, and stay in HALT until reset.
REQ-027 active SHALL be 1 in every state except IDLE and HALT.
REQ-028 mem_read and mem_write SHALL never be high in the same cycle.
REQ-029 All outputs SHALL be a combinational decode of the state register and its inputs (Moore/Mealy mix); only the state register is sequential.

Reset
REQ-030 reset=1 SHALL force IDLE asynchronously from any state, including mid-stall; outputs SHALL go to 0 in the same cycle.
REQ-031 A reset pulse shorter than one clk period SHALL still leave the FSM in IDLE.

Structure
REQ-032 The state enum, opcode/funct constants and pc_src encodings SHALL live in the shared package mips_cpu_pkg.
REQ-033 Opcode classification (is_rtype_alu, is_itype_alu, is_branch, is_jr, is_load, is_store) SHALL be one combinational sub-module, mips_cpu_decode.

Verification
REQ-034 Reset release -> IDLE for one cycle, then FETCH with mem_read=1 and active=1.
REQ-035 addu (op 0, funct 0x21), waitrequest=0 -> FETCH, DECODE, EXEC, WB, FETCH (5 cycles); reg_write=1, reg_dst=1 only in WB.
REQ-036 lw with waitrequest=1 for 3 cycles in MEM -> MEM held 4 cycles, alu_opcode=0x09 in EXEC, mem_to_reg=1 in WB.
REQ-037 beq with sig_branch=1 -> pc_write=1 and pc_src=1 in EXEC, then FETCH; with sig_branch=0 -> pc_write=0 in EXEC.
REQ-038 jr with jump_target_zero=1 -> HALT, active=0 and held for 10 cycles; reset asserted mid-FETCH stall -> IDLE immediately.
